// File: rtl/iterator_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iterator_frame_pkg
// Description : Shared constants and state encoding for the iterator frame
//               controller. Coordinates are 4.23 signed fixed point.
// Revision    : 1.0 - initial release
// ============================================================================
package iterator_frame_pkg;

  // 4 integer bits (including sign) + 23 fractional bits = 27-bit word
  localparam int c_FP_INT_BITS = 4;
  localparam int c_FP_FRAC     = 23;
  localparam int c_FP_W        = c_FP_INT_BITS + c_FP_FRAC;

  localparam int c_MAX_ITER_W  = 32;
  localparam int c_FRAME_CNT_W = 16;
  localparam int c_PERF_W      = 32;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } frame_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [c_PERF_W-1:0] sat_inc(input logic [c_PERF_W-1:0] v);
    return (v == {c_PERF_W{1'b1}}) ? v : v + {{(c_PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iterator_frame_accum.sv
`default_nettype none
// ============================================================================
// Module      : iterator_frame_accum
// Description : LOAD-phase accumulator. Walks the partition index and sums the
//               per-pixel x step so that each partition gets base + p*step and,
//               once every partition is written, the sum equals the shared
//               PARTITION*step column increment (all mod 2^27).
// Revision    : 1.0 - initial release
// ============================================================================
module iterator_frame_accum
  import iterator_frame_pkg::*;
#(
  parameter int PARTITION  = 2,
  parameter int PART_IDX_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_step_en,
  input  logic [c_FP_W-1:0]     i_base,
  input  logic [c_FP_W-1:0]     i_step,
  output logic [PART_IDX_W-1:0] o_idx,
  output logic                  o_last,
  output logic [c_FP_W-1:0]     o_coord,
  output logic [c_FP_W-1:0]     o_incr
);

  localparam logic [PART_IDX_W-1:0] c_LAST_IDX = PART_IDX_W'(PARTITION - 1);

  logic [PART_IDX_W-1:0] r_idx;
  logic [c_FP_W-1:0]     r_acc;
  logic                  w_last;

  assign w_last = (r_idx == c_LAST_IDX);

  // Index and step sum: cleared on frame accept, advanced once per LOAD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_step_en) begin
      r_acc <= r_acc + i_step;
      if (!w_last) begin
        r_idx <= r_idx + PART_IDX_W'(1);
      end
    end
  end

  assign o_idx   = r_idx;
  assign o_last  = w_last;
  assign o_coord = i_base + r_acc;
  assign o_incr  = r_acc;

endmodule
`default_nettype wire

// File: rtl/iterator_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iterator_frame_ctrl
// Description : Frame controller for a partitioned escape-time iterator array.
//               Accepts a frame request, writes per-partition start
//               coordinates, pulses start, waits for done and reports
//               completion. Optional render-cycle counter enabled by macro
//               ITER_FRAME_PERF_EN (render_cycles reads 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module iterator_frame_ctrl
  import iterator_frame_pkg::*;
#(
  parameter int PARTITION  = 2,
  parameter int PART_IDX_W = (PARTITION > 1) ? $clog2(PARTITION) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // frame request
  input  logic                     i_cfg_valid,
  output logic                     o_cfg_ready,
  input  logic [c_FP_W-1:0]        i_cfg_x0,
  input  logic [c_FP_W-1:0]        i_cfg_y0,
  input  logic [c_FP_W-1:0]        i_cfg_dx,
  input  logic [c_FP_W-1:0]        i_cfg_dy,
  input  logic [c_MAX_ITER_W-1:0]  i_cfg_max_iter,
  input  logic                     i_abort,
  // partition start-coordinate write port
  output logic                     o_part_wr,
  output logic [PART_IDX_W-1:0]    o_part_idx,
  output logic [c_FP_W-1:0]        o_part_init_x,
  output logic [c_FP_W-1:0]        o_part_init_y,
  // shared iterator controls
  output logic [c_FP_W-1:0]        o_iter_x_incr,
  output logic [c_FP_W-1:0]        o_iter_y_incr,
  output logic [c_MAX_ITER_W-1:0]  o_iter_max_iter,
  output logic                     o_iter_start,
  input  logic                     i_iter_done,
  // status
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic [c_FRAME_CNT_W-1:0] o_frame_count,
  output logic [c_PERF_W-1:0]      o_render_cycles
);

  frame_state_t r_state;
  frame_state_t w_state_nxt;

  logic [c_FP_W-1:0]        r_cfg_x0;
  logic [c_FP_W-1:0]        r_cfg_y0;
  logic [c_FP_W-1:0]        r_cfg_dx;
  logic [c_FP_W-1:0]        r_cfg_dy;
  logic [c_MAX_ITER_W-1:0]  r_cfg_max_iter;
  logic                     r_run_first;
  logic [c_FRAME_CNT_W-1:0] r_frame_count;

  logic                     w_accept;
  logic                     w_cfg_ready;
  logic                     w_part_wr;
  logic                     w_iter_start;
  logic                     w_busy;
  logic                     w_frame_done;
  logic                     w_load_last;
  logic [PART_IDX_W-1:0]    w_load_idx;
  logic [c_FP_W-1:0]        w_load_x;
  logic [c_FP_W-1:0]        w_x_incr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore outputs; abort outranks done in RUN
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_cfg_ready  = 1'b0;
    w_part_wr    = 1'b0;
    w_iter_start = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy      = 1'b0;
        w_cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_part_wr = 1'b1;
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_load_last) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_iter_start = 1'b1;
        w_state_nxt  = i_abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        // done seen in the first RUN cycle is left over from the last frame
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (!r_run_first && i_iter_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the frame request on handshake; held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_x0       <= '0;
      r_cfg_y0       <= '0;
      r_cfg_dx       <= '0;
      r_cfg_dy       <= '0;
      r_cfg_max_iter <= '0;
    end else if (w_accept) begin
      r_cfg_x0       <= i_cfg_x0;
      r_cfg_y0       <= i_cfg_y0;
      r_cfg_dx       <= i_cfg_dx;
      r_cfg_dy       <= i_cfg_dy;
      r_cfg_max_iter <= i_cfg_max_iter;
    end
  end

  // Flag the first RUN cycle (the cycle right after START)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_first <= 1'b0;
    end else begin
      r_run_first <= (r_state == ST_START);
    end
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= '0;
    end else if (w_frame_done) begin
      r_frame_count <= r_frame_count + {{(c_FRAME_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  iterator_frame_accum #(
    .PARTITION  (PARTITION),
    .PART_IDX_W (PART_IDX_W)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_accept),
    .i_step_en (w_part_wr),
    .i_base    (r_cfg_x0),
    .i_step    (r_cfg_dx),
    .o_idx     (w_load_idx),
    .o_last    (w_load_last),
    .o_coord   (w_load_x),
    .o_incr    (w_x_incr)
  );

`ifdef ITER_FRAME_PERF_EN
  logic [c_PERF_W-1:0] r_perf_cnt;
  logic [c_PERF_W-1:0] r_render_cycles;

  // Count START..RUN cycles; DONE adds its own cycle when publishing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt      <= '0;
      r_render_cycles <= '0;
    end else begin
      if (w_accept) begin
        r_perf_cnt <= '0;
      end else if (r_state == ST_START) begin
        r_perf_cnt <= {{(c_PERF_W-1){1'b0}}, 1'b1};
      end else if (r_state == ST_RUN) begin
        r_perf_cnt <= sat_inc(r_perf_cnt);
      end
      if (w_frame_done) begin
        r_render_cycles <= sat_inc(r_perf_cnt);
      end
    end
  end

  assign o_render_cycles = r_render_cycles;
`else
  assign o_render_cycles = '0;
`endif

  assign o_cfg_ready     = w_cfg_ready;
  assign o_busy          = w_busy;
  assign o_frame_done    = w_frame_done;
  assign o_iter_start    = w_iter_start;
  assign o_part_wr       = w_part_wr;
  assign o_part_idx      = w_load_idx;
  assign o_part_init_x   = w_load_x;
  assign o_part_init_y   = r_cfg_y0;
  assign o_iter_x_incr   = w_x_incr;
  assign o_iter_y_incr   = r_cfg_dy;
  assign o_iter_max_iter = r_cfg_max_iter;
  assign o_frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_iterator_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterator_frame_ctrl
// Description : Self-checking bench for iterator_frame_ctrl with randomized
//               frame requests and a cycle-level expectation of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterator_frame_ctrl;

  localparam int P  = 2;
  localparam int IW = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [26:0] i_cfg_x0 = '0, i_cfg_y0 = '0, i_cfg_dx = '0, i_cfg_dy = '0;
  logic [31:0] i_cfg_max_iter = '0;
  logic        i_abort = 1'b0;
  logic        o_part_wr;
  logic [IW-1:0] o_part_idx;
  logic [26:0] o_part_init_x, o_part_init_y, o_iter_x_incr, o_iter_y_incr;
  logic [31:0] o_iter_max_iter;
  logic        o_iter_start;
  logic        i_iter_done = 1'b0;
  logic        o_busy, o_frame_done;
  logic [15:0] o_frame_count;
  logic [31:0] o_render_cycles;

  int checks = 0;
  int failures = 0;

  // configuration of the frame currently expected, and of a chained next one
  logic [26:0] c_x0, c_dx, c_y0, c_dy, n_x0, n_dx, n_y0, n_dy;
  logic [31:0] c_max, n_max;
  logic [15:0] exp_fc = '0;
  logic [31:0] exp_rc = '0;

  always #5 clk = ~clk;

  iterator_frame_ctrl #(.PARTITION(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_x0(i_cfg_x0), .i_cfg_y0(i_cfg_y0), .i_cfg_dx(i_cfg_dx), .i_cfg_dy(i_cfg_dy),
    .i_cfg_max_iter(i_cfg_max_iter), .i_abort(i_abort),
    .o_part_wr(o_part_wr), .o_part_idx(o_part_idx),
    .o_part_init_x(o_part_init_x), .o_part_init_y(o_part_init_y),
    .o_iter_x_incr(o_iter_x_incr), .o_iter_y_incr(o_iter_y_incr),
    .o_iter_max_iter(o_iter_max_iter), .o_iter_start(o_iter_start),
    .i_iter_done(i_iter_done), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frame_count(o_frame_count), .o_render_cycles(o_render_cycles)
  );

  // Frame length seen by the perf counter: START + RUN cycles + DONE
  function automatic logic [31:0] exp_render(input int run_len);
`ifdef ITER_FRAME_PERF_EN
    return 32'(run_len + 2);
`else
    return 32'd0;
`endif
  endfunction

  // Present a request on the pins (caller is just past a negedge, DUT in IDLE)
  task automatic kick(input logic [26:0] x0, dx, y0, dy, input logic [31:0] mx, input bit ab);
    c_x0 = x0; c_dx = dx; c_y0 = y0; c_dy = dy; c_max = mx;
    i_cfg_x0 = x0; i_cfg_dx = dx; i_cfg_y0 = y0; i_cfg_dy = dy; i_cfg_max_iter = mx;
    i_cfg_valid = 1'b1;
    i_abort = ab;
  endtask

  task automatic kick_rand(input bit ab);
    kick(27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom), $urandom, ab);
  endtask

  task automatic scramble_pins();
    i_cfg_x0 = 27'($urandom); i_cfg_dx = 27'($urandom);
    i_cfg_y0 = 27'($urandom); i_cfg_dy = 27'($urandom);
    i_cfg_max_iter = $urandom;
  endtask

  // One full frame from the cycle after accept through the return to IDLE
  task automatic do_frame(input int run_len, input bit chain, input bit stale_done);
    logic [26:0] ex, ex_incr;
    ex_incr = c_dx * 27'(P);
    for (int p = 0; p < P; p++) begin
      @(negedge clk);
      if (p == 0) begin
        i_cfg_valid = 1'b0;
        i_abort = 1'b0;
        scramble_pins();
      end
      ex = c_x0 + c_dx * 27'(p);
      checks++;
      if ({o_part_wr, o_part_idx, o_part_init_x, o_part_init_y} !== {1'b1, IW'(p), ex, c_y0}) begin
        failures++;
        $display("FAIL load_write p=%0d: got wr=%b idx=%0d x=%h y=%h want wr=1 idx=%0d x=%h y=%h",
                 p, o_part_wr, o_part_idx, o_part_init_x, o_part_init_y, p, ex, c_y0);
      end
      checks++;
      if ({o_busy, o_cfg_ready, o_iter_start, o_frame_done} !== 4'b1000) begin
        failures++;
        $display("FAIL load_status: got busy/rdy/start/done=%b want 1000",
                 {o_busy, o_cfg_ready, o_iter_start, o_frame_done});
      end
    end
    @(negedge clk);
    checks++;
    if ({o_iter_start, o_part_wr, o_busy} !== 3'b101) begin
      failures++;
      $display("FAIL start_pulse: got start/wr/busy=%b want 101", {o_iter_start, o_part_wr, o_busy});
    end
    checks++;
    if ({o_iter_x_incr, o_iter_y_incr, o_iter_max_iter} !== {ex_incr, c_dy, c_max}) begin
      failures++;
      $display("FAIL start_shared: got xi=%h yi=%h max=%h want xi=%h yi=%h max=%h",
               o_iter_x_incr, o_iter_y_incr, o_iter_max_iter, ex_incr, c_dy, c_max);
    end
    if (stale_done) i_iter_done = 1'b1;
    for (int k = 1; k <= run_len; k++) begin
      @(negedge clk);
      if (k == 1 && chain) begin
        n_x0 = 27'($urandom); n_dx = 27'($urandom); n_y0 = 27'($urandom);
        n_dy = 27'($urandom); n_max = $urandom;
        i_cfg_x0 = n_x0; i_cfg_dx = n_dx; i_cfg_y0 = n_y0; i_cfg_dy = n_dy;
        i_cfg_max_iter = n_max;
        i_cfg_valid = 1'b1;
      end
      i_iter_done = (k == run_len) || (stale_done && k == 1);
      checks++;
      if ({o_iter_start, o_part_wr, o_frame_done, o_busy, o_cfg_ready} !== 5'b00010) begin
        failures++;
        $display("FAIL run_status k=%0d: got start/wr/done/busy/rdy=%b want 00010", k,
                 {o_iter_start, o_part_wr, o_frame_done, o_busy, o_cfg_ready});
      end
      checks++;
      if ({o_iter_x_incr, o_iter_y_incr, o_iter_max_iter} !== {ex_incr, c_dy, c_max}) begin
        failures++;
        $display("FAIL run_hold k=%0d: got xi=%h yi=%h max=%h want xi=%h yi=%h max=%h", k,
                 o_iter_x_incr, o_iter_y_incr, o_iter_max_iter, ex_incr, c_dy, c_max);
      end
    end
    @(negedge clk);
    i_iter_done = 1'b0;
    i_abort = 1'($urandom);
    checks++;
    if ({o_frame_done, o_busy, o_cfg_ready} !== 3'b110) begin
      failures++;
      $display("FAIL done_pulse: got done/busy/rdy=%b want 110", {o_frame_done, o_busy, o_cfg_ready});
    end
    checks++;
    if ({o_frame_count, o_render_cycles} !== {exp_fc, exp_rc}) begin
      failures++;
      $display("FAIL done_counts: got fc=%0d rc=%0d want fc=%0d rc=%0d",
               o_frame_count, o_render_cycles, exp_fc, exp_rc);
    end
    exp_fc = exp_fc + 16'd1;
    exp_rc = exp_render(run_len);
    @(negedge clk);
    i_abort = 1'b0;
    checks++;
    if ({o_frame_done, o_busy, o_cfg_ready, o_iter_start, o_part_wr} !== 5'b00100) begin
      failures++;
      $display("FAIL idle_status: got done/busy/rdy/start/wr=%b want 00100",
               {o_frame_done, o_busy, o_cfg_ready, o_iter_start, o_part_wr});
    end
    checks++;
    if ({o_frame_count, o_render_cycles} !== {exp_fc, exp_rc}) begin
      failures++;
      $display("FAIL idle_counts: got fc=%0d rc=%0d want fc=%0d rc=%0d",
               o_frame_count, o_render_cycles, exp_fc, exp_rc);
    end
    if (chain) begin
      c_x0 = n_x0; c_dx = n_dx; c_y0 = n_y0; c_dy = n_dy; c_max = n_max;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_cfg_ready, o_busy, o_frame_done, o_iter_start, o_part_wr} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_status: got rdy/busy/done/start/wr=%b want 10000",
               {o_cfg_ready, o_busy, o_frame_done, o_iter_start, o_part_wr});
    end
    checks++;
    if ({o_part_idx, o_part_init_x, o_part_init_y, o_iter_x_incr, o_iter_y_incr,
         o_iter_max_iter, o_frame_count, o_render_cycles} !== '0) begin
      failures++;
      $display("FAIL reset_values: got idx=%0d x=%h y=%h xi=%h yi=%h max=%h fc=%0d rc=%0d want all 0",
               o_part_idx, o_part_init_x, o_part_init_y, o_iter_x_incr, o_iter_y_incr,
               o_iter_max_iter, o_frame_count, o_render_cycles);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // -2.0 start, 0x000C000 column step, 1.0 row, -0x0008000 row step
  task automatic test_directed();
    kick(27'h7000000, 27'h000C000, 27'h0800000, 27'h7FF8000, 32'd1000, 1'b0);
    do_frame(3, 1'b0, 1'b0);
  endtask

  task automatic test_stale_done();
    kick_rand(1'b0);
    do_frame(2, 1'b0, 1'b1);
    kick_rand(1'b1);
    do_frame(5, 1'b0, 1'b1);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 6; i++) begin
      kick_rand(1'($urandom));
      do_frame(2 + int'($urandom_range(0, 6)), 1'b0, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    kick_rand(1'b0);
    do_frame(4, 1'b1, 1'b0);
    do_frame(3, 1'b1, 1'b1);
    do_frame(2, 1'b0, 1'b0);
  endtask

  task automatic test_perf();
    kick_rand(1'b0);
    do_frame(100, 1'b0, 1'b0);
  endtask

  // where: 0 = LOAD, 1 = START, 2 = RUN (with a simultaneous done)
  task automatic test_abort(input int where);
    int a;
    a = (where == 0) ? int'($urandom_range(0, P - 1)) :
        (where == 1) ? P : P + 1 + int'($urandom_range(0, 3));
    kick_rand(1'b0);
    for (int c = 0; c <= a; c++) begin
      @(negedge clk);
      if (c == 0) begin
        i_cfg_valid = 1'b0;
        scramble_pins();
      end
      checks++;
      if ({o_part_wr, o_iter_start, o_busy} !== {c < P, c == P, 1'b1}) begin
        failures++;
        $display("FAIL abort_walk c=%0d: got wr/start/busy=%b want %b", c,
                 {o_part_wr, o_iter_start, o_busy}, {c < P, c == P, 1'b1});
      end
      if (c == a) begin
        i_abort = 1'b1;
        if (where == 2) i_iter_done = 1'b1;
      end
    end
    @(negedge clk);
    i_abort = 1'b0;
    i_iter_done = 1'b0;
    checks++;
    if ({o_busy, o_cfg_ready, o_frame_done} !== 3'b010) begin
      failures++;
      $display("FAIL abort_idle where=%0d: got busy/rdy/done=%b want 010", where,
               {o_busy, o_cfg_ready, o_frame_done});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({o_frame_done, o_part_wr, o_iter_start, o_frame_count, o_render_cycles} !==
          {3'b000, exp_fc, exp_rc}) begin
        failures++;
        $display("FAIL abort_quiet where=%0d: got done/wr/start=%b fc=%0d rc=%0d want 000 fc=%0d rc=%0d",
                 where, {o_frame_done, o_part_wr, o_iter_start}, o_frame_count, o_render_cycles,
                 exp_fc, exp_rc);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    kick_rand(1'b0);
    @(negedge clk);
    i_cfg_valid = 1'b0;
    checks++;
    if (o_part_wr !== 1'b1) begin
      failures++;
      $display("FAIL midload_wr: got %b want 1", o_part_wr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_cfg_ready, o_busy, o_frame_done, o_iter_start, o_part_wr} !== 5'b10000) begin
      failures++;
      $display("FAIL async_reset_status: got rdy/busy/done/start/wr=%b want 10000",
               {o_cfg_ready, o_busy, o_frame_done, o_iter_start, o_part_wr});
    end
    checks++;
    if ({o_part_idx, o_part_init_x, o_part_init_y, o_iter_x_incr, o_iter_y_incr,
         o_iter_max_iter, o_frame_count, o_render_cycles} !== '0) begin
      failures++;
      $display("FAIL async_reset_values: got idx=%0d x=%h xi=%h max=%h fc=%0d rc=%0d want all 0",
               o_part_idx, o_part_init_x, o_iter_x_incr, o_iter_max_iter, o_frame_count,
               o_render_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = '0;
    exp_rc = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({o_part_wr, o_frame_done, o_busy, o_cfg_ready} !== 4'b0001) begin
        failures++;
        $display("FAIL post_reset c=%0d: got wr/done/busy/rdy=%b want 0001", c,
                 {o_part_wr, o_frame_done, o_busy, o_cfg_ready});
      end
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_stale_done();
    test_random_frames();
    test_back_to_back();
    test_perf();
    for (int w = 0; w < 3; w++) begin
      test_abort(w);
      test_abort(w);
    end
    test_reset_mid_load();
    kick_rand(1'b0);
    do_frame(3, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
